// File: rtl/regfile_dump_reader.sv
// Register file dump master: walks registers 0..NUM_REGS-1 through a spare read
// port and streams (index, value) pairs out over valid/ready, holding writes meanwhile.
module regfile_dump_reader #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  hold_writes,
  output logic [ADDR_WIDTH-1:0] rf_read_reg,
  input  logic [DATA_WIDTH-1:0] rf_read_data,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic [DATA_WIDTH-1:0] dump_data
);

  // Terminal index is computed at elaboration so NUM_REGS == 2**ADDR_WIDTH never overflows.
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] idx;

  assign rf_read_reg = idx;
  assign hold_writes = busy;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= READ;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        READ: begin
          dump_data  <= rf_read_data;
          dump_addr  <= idx;
          dump_valid <= 1'b1;
          state      <= SEND;
        end
        SEND: begin
          // dump_valid is always high here, so ready alone completes the handshake.
          if (dump_ready) begin
            dump_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              state <= READ;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          idx   <= '0;
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: cycle table for a full dump, hand-written corner
// sequences, and randomized dumps checked against a snapshot-of-the-register-file model.
module tb_regfile_dump_reader;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          start, start1;
  logic          busy, done, hold_writes;
  logic          busy1, done1, hold_writes1;
  logic [AW-1:0] rf_read_reg, rf_read_reg1;
  logic [DW-1:0] rf_read_data, rf_read_data1;
  logic          dump_valid, dump_ready, dump_valid1, dump_ready1;
  logic [AW-1:0] dump_addr, dump_addr1;
  logic [DW-1:0] dump_data, dump_data1;

  always #5 clock = ~clock;

  regfile_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .hold_writes(hold_writes), .rf_read_reg(rf_read_reg), .rf_read_data(rf_read_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
    .dump_data(dump_data)
  );

  regfile_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .hold_writes(hold_writes1), .rf_read_reg(rf_read_reg1), .rf_read_data(rf_read_data1),
    .dump_valid(dump_valid1), .dump_ready(dump_ready1), .dump_addr(dump_addr1),
    .dump_data(dump_data1)
  );

  // Register file model with a datapath write port gated by hold_writes.
  logic [DW-1:0] rf       [NR];
  logic [DW-1:0] load_img [NR];
  logic          load_en, wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  assign rf_read_data  = rf[rf_read_reg];
  assign rf_read_data1 = rf[rf_read_reg1];

  always @(posedge clock) begin
    if (load_en) begin
      for (int i = 0; i < NR; i++) rf[i] <= load_img[i];
    end else if (wr_en && !hold_writes) begin
      rf[wr_addr] <= wr_data;
    end
  end

  // Monitor: every accepted pair and every done cycle of the 32-register instance.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } pair_t;

  pair_t got_q[$];
  int    done_cnt = 0;

  always @(posedge clock) begin
    if (!reset && dump_valid && dump_ready) got_q.push_back({dump_addr, dump_data});
    if (done) done_cnt <= done_cnt + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] bcd_val(input int i);
    return DW'(((i / 10) << 4) | (i % 10));
  endfunction

  task automatic preload(input bit random_img);
    for (int i = 0; i < NR; i++) load_img[i] = random_img ? DW'($urandom) : bcd_val(i);
    load_en = 1'b1;
    @(negedge clock);
    load_en = 1'b0;
  endtask

  // One complete dump. Expected stream is (i, snapshot[i]) for every i, exactly once,
  // in order, followed by a single done pulse.
  //   ready_pct    : chance of dump_ready each cycle
  //   restart_pair : pulse start while this pair is presented (-1 = never)
  //   stall_pair   : hold ready low for 5 cycles on this pair (-1 = never)
  //   wr_mode      : 0 none, 1 random writes while busy, 2 write 0xDEADBEEF to reg 5 while busy
  task automatic run_dump(input int ready_pct, input int restart_pair,
                          input int stall_pair, input int wr_mode);
    logic [DW-1:0] snap [NR];
    int base_q, base_done, cyc, stalls;
    bit finished, stalled;
    snap      = rf;
    base_q    = got_q.size();
    base_done = done_cnt;
    stalls    = 0;
    finished  = 1'b0;
    cyc       = 0;
    start     = 1'b1;
    @(negedge clock);
    start = 1'b0;
    while (!finished && cyc < 3000) begin
      dump_ready = ($urandom_range(99) < ready_pct);
      stalled    = 1'b0;
      if (stall_pair >= 0 && dump_valid && int'(dump_addr) == stall_pair && stalls < 5) begin
        dump_ready = 1'b0;
        stalled    = 1'b1;
        stalls++;
      end
      start   = (restart_pair >= 0 && dump_valid && int'(dump_addr) == restart_pair);
      wr_en   = 1'b0;
      wr_addr = AW'($urandom);
      wr_data = DW'($urandom);
      if (wr_mode == 1) wr_en = busy && ($urandom_range(3) == 0);
      if (wr_mode == 2) begin
        wr_en   = busy;
        wr_addr = AW'(5);
        wr_data = 32'hDEADBEEF;
      end
      @(negedge clock);
      check("hold_eq_busy", 64'(hold_writes), 64'(busy));
      if (stalled) begin
        check("stall_valid", 64'(dump_valid), 64'(1));
        check("stall_addr", 64'(dump_addr), 64'(stall_pair));
        check("stall_data", 64'(dump_data), 64'(snap[stall_pair]));
      end
      if (done) finished = 1'b1;
      cyc++;
    end
    start      = 1'b0;
    wr_en      = 1'b0;
    dump_ready = 1'b0;
    check("dump_timeout", 64'(finished), 64'(1));
    @(negedge clock);
    check("pair_count", 64'(got_q.size() - base_q), 64'(NR));
    for (int i = 0; i < NR && base_q + i < got_q.size(); i++) begin
      check($sformatf("pair%0d_addr", i), 64'(got_q[base_q + i].a), 64'(i));
      check($sformatf("pair%0d_data", i), 64'(got_q[base_q + i].d), 64'(snap[i]));
    end
    check("done_pulses", 64'(done_cnt - base_done), 64'(1));
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_rreg", 64'(rf_read_reg), 64'(0));
  endtask

  // Cycle table for a full dump with dump_ready tied high; cyc n = sampled after edge T+n.
  typedef struct {
    int   cyc;
    logic busy;
    logic done;
    logic valid;
    int   addr;   // -1: don't check addr/data
    int   rreg;   // -1: don't check rf_read_reg
  } vec_t;

  vec_t vecs [9];

  initial begin
    int base_q, base_done;
    bit hit;

    vecs[0] = '{0,  1'b1, 1'b0, 1'b0, -1, 0};
    vecs[1] = '{1,  1'b1, 1'b0, 1'b1, 0,  0};
    vecs[2] = '{2,  1'b1, 1'b0, 1'b0, -1, 1};
    vecs[3] = '{3,  1'b1, 1'b0, 1'b1, 1,  1};
    vecs[4] = '{21, 1'b1, 1'b0, 1'b1, 10, 10};
    vecs[5] = '{62, 1'b1, 1'b0, 1'b0, -1, 31};
    vecs[6] = '{63, 1'b1, 1'b0, 1'b1, 31, 31};
    vecs[7] = '{64, 1'b0, 1'b1, 1'b0, -1, 31};
    vecs[8] = '{65, 1'b0, 1'b0, 1'b0, -1, 0};

    reset = 1'b1; start = 1'b0; start1 = 1'b0; dump_ready = 1'b0; dump_ready1 = 1'b1;
    load_en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_valid", 64'(dump_valid), 64'(0));
    check("rst_hold", 64'(hold_writes), 64'(0));
    check("rst_addr", 64'(dump_addr), 64'(0));
    check("rst_data", 64'(dump_data), 64'(0));
    check("rst_rreg", 64'(rf_read_reg), 64'(0));
    reset = 1'b0;
    preload(1'b0);

    // Full dump timing table.
    base_q = got_q.size(); base_done = done_cnt;
    start = 1'b1; dump_ready = 1'b1;
    for (int n = 0; n <= 65; n++) begin
      @(negedge clock);
      start = 1'b0;
      check($sformatf("t%0d_valid", n), 64'(dump_valid), 64'(n >= 1 && n <= 63 && n % 2 == 1));
      check($sformatf("t%0d_busy", n), 64'(busy), 64'(n <= 63));
      if (n >= 1 && n <= 63 && n % 2 == 1)
        check($sformatf("t%0d_addr", n), 64'(dump_addr), 64'((n - 1) / 2));
      for (int v = 0; v < 9; v++) begin
        if (vecs[v].cyc == n) begin
          check($sformatf("v%0d_busy", v), 64'(busy), 64'(vecs[v].busy));
          check($sformatf("v%0d_hold", v), 64'(hold_writes), 64'(vecs[v].busy));
          check($sformatf("v%0d_done", v), 64'(done), 64'(vecs[v].done));
          check($sformatf("v%0d_valid", v), 64'(dump_valid), 64'(vecs[v].valid));
          if (vecs[v].addr >= 0) begin
            check($sformatf("v%0d_addr", v), 64'(dump_addr), 64'(vecs[v].addr));
            check($sformatf("v%0d_data", v), 64'(dump_data), 64'(bcd_val(vecs[v].addr)));
          end
          if (vecs[v].rreg >= 0)
            check($sformatf("v%0d_rreg", v), 64'(rf_read_reg), 64'(vecs[v].rreg));
        end
      end
    end
    dump_ready = 1'b0;
    check("full_pairs", 64'(got_q.size() - base_q), 64'(NR));
    for (int i = 0; i < NR && base_q + i < got_q.size(); i++)
      check($sformatf("full%0d", i), 64'(got_q[base_q + i]), 64'({AW'(i), bcd_val(i)}));
    check("full_done", 64'(done_cnt - base_done), 64'(1));

    // Backpressure on pair 7, then a start pulse while busy at pair 12.
    run_dump(100, -1, 7, 0);
    run_dump(100, 12, -1, 0);
    repeat (2) @(negedge clock);
    check("no_queued_start", 64'(busy), 64'(0));

    // Reset at the edge that would accept pair 20.
    base_q = got_q.size(); base_done = done_cnt;
    start = 1'b1; dump_ready = 1'b1; hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (dump_valid && dump_addr == AW'(20)) hit = 1'b1;
    end
    check("rst_mid_reach20", 64'(hit), 64'(1));
    reset = 1'b1;
    @(negedge clock);
    check("rstm_valid", 64'(dump_valid), 64'(0));
    check("rstm_busy", 64'(busy), 64'(0));
    check("rstm_hold", 64'(hold_writes), 64'(0));
    check("rstm_addr", 64'(dump_addr), 64'(0));
    check("rstm_done", 64'(done), 64'(0));
    reset = 1'b0; dump_ready = 1'b0;
    repeat (2) @(negedge clock);
    check("rstm_no_done", 64'(done_cnt - base_done), 64'(0));
    check("rstm_pairs", 64'(got_q.size() - base_q), 64'(20));
    run_dump(100, -1, -1, 0);

    // Coherency: write to reg 5 during the dump is held off, then allowed afterwards.
    run_dump(100, -1, -1, 2);
    check("coh_rf5_held", 64'(rf[5]), 64'(bcd_val(5)));
    wr_en = 1'b1; wr_addr = AW'(5); wr_data = 32'hDEADBEEF;
    @(negedge clock);
    wr_en = 1'b0;
    check("coh_rf5_written", 64'(rf[5]), 64'(32'hDEADBEEF));
    run_dump(100, -1, -1, 0);

    // Randomized contents, backpressure and gated write attempts.
    for (int r = 0; r < 5; r++) begin
      preload(1'b1);
      run_dump(int'($urandom_range(30, 90)), -1, -1, 1);
    end

    // Single-register instance.
    preload(1'b0);
    start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    check("n1_t0_busy", 64'(busy1), 64'(1));
    check("n1_t0_valid", 64'(dump_valid1), 64'(0));
    @(negedge clock);
    check("n1_t1_valid", 64'(dump_valid1), 64'(1));
    check("n1_t1_pair", 64'({dump_addr1, dump_data1}), 64'({AW'(0), bcd_val(0)}));
    @(negedge clock);
    check("n1_t2_done", 64'(done1), 64'(1));
    check("n1_t2_busy", 64'(busy1), 64'(0));
    check("n1_t2_valid", 64'(dump_valid1), 64'(0));
    @(negedge clock);
    check("n1_t3_done", 64'(done1), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
